// File: rtl/dma_pkg.sv
// dma_pkg: shared types and constants for the word-granular DMA copy engine.
//   dma_state_t  : top-level transfer FSM states
//   WORD_BYTES   : bytes per transferred word (addresses step by this amount)
//   LEN_WIDTH    : width of the length and word counters
//   word_offset(): byte offset of word index idx
package dma_pkg;

  typedef enum logic [1:0] {
    DMA_IDLE = 2'd0,
    DMA_XFER = 2'd1,
    DMA_DONE = 2'd2
  } dma_state_t;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned LEN_WIDTH  = 16;

  // Word index to byte offset; WORD_BYTES is 4, so this is a 2-bit shift.
  function automatic logic [LEN_WIDTH+1:0] word_offset(input logic [LEN_WIDTH-1:0] idx);
    return {idx, 2'b00};
  endfunction

endpackage

// File: rtl/dma_fifo.sv
// dma_fifo: synchronous FIFO with asynchronous active-high reset.
// Ports:
//   clk, rst  : clock and asynchronous active-high reset
//   push_i    : write din_i at the tail
//   pop_i     : drop the head entry
//   din_i     : write data
//   dout_o    : head entry (a push into an empty FIFO appears here one cycle later)
//   count_o   : number of stored entries (0..DEPTH)
//   full_o    : count_o == DEPTH
//   empty_o   : count_o == 0
module dma_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Illegal strobes are dropped so the storage stays consistent.
  assign push_ok_s = push_i && !full_o;
  assign pop_ok_s  = pop_i && !empty_o;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // Storage, pointers (wrap naturally at power-of-2 DEPTH) and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok_s) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  dma_fifo_chk u_chk (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_i),
    .pop_i   (pop_i),
    .full_i  (full_o),
    .empty_i (empty_o)
  );

endmodule

// File: rtl/dma_fifo_chk.sv
// dma_fifo_chk: protocol checker for dma_fifo.
// Ports:
//   clk, rst        : clock and asynchronous active-high reset
//   push_i, pop_i   : FIFO write/read strobes
//   full_i, empty_i : FIFO status flags
module dma_fifo_chk (
  input logic clk,
  input logic rst,
  input logic push_i,
  input logic pop_i,
  input logic full_i,
  input logic empty_i
);

  // A push into a full FIFO would overwrite unread data.
  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(push_i && full_i));

  // A pop from an empty FIFO would return stale data.
  a_no_pop_when_empty: assert property (@(posedge clk) disable iff (rst) !(pop_i && empty_i));

endmodule

// File: rtl/dma_engine.sv
// dma_engine: word-granular copy engine. Reads length_i words from src_addr_i over the read
// master, buffers them in a small FIFO, and writes them in ascending order to dst_addr_i over
// the write master.
// Ports:
//   clk, rst                      : clock and asynchronous active-high reset
//   dma_start_i                   : 1-cycle start pulse; src/dst/length sampled with it (IDLE only)
//   src_addr_i, dst_addr_i        : byte addresses, bits [1:0] ignored
//   length_i                      : transfer length in words (0 completes with no bus traffic)
//   dma_done_o                    : 1-cycle completion pulse
//   dma_busy_o                    : high from the cycle after an accepted start through dma_done_o
//   rd_req_valid_o/ready_i/addr_o : read request channel
//   rd_resp_valid_i/data_i        : in-order read data, no backpressure
//   wr_req_valid_o/ready_i/addr_o/data_o : write request channel (ready = write complete)
module dma_engine
  import dma_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_SIZE  = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dma_start_i,
  input  logic [ADDR_WIDTH-1:0] src_addr_i,
  input  logic [ADDR_WIDTH-1:0] dst_addr_i,
  input  logic [LEN_WIDTH-1:0]  length_i,
  output logic                  dma_done_o,
  output logic                  dma_busy_o,
  output logic                  rd_req_valid_o,
  input  logic                  rd_req_ready_i,
  output logic [ADDR_WIDTH-1:0] rd_req_addr_o,
  input  logic                  rd_resp_valid_i,
  input  logic [DATA_SIZE-1:0]  rd_resp_data_i,
  output logic                  wr_req_valid_o,
  input  logic                  wr_req_ready_i,
  output logic [ADDR_WIDTH-1:0] wr_req_addr_o,
  output logic [DATA_SIZE-1:0]  wr_req_data_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

  dma_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;
  logic [LEN_WIDTH-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]         outst_q, outst_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;

  logic [CW-1:0]         fifo_count_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic [DATA_SIZE-1:0]  fifo_head_s;
  logic                  credit_ok_s;
  logic                  rd_fire_s;
  logic                  wr_fire_s;
  logic                  push_s;

  // Responses cannot be stalled, so a read may only be issued when buffered plus in-flight
  // words leave room for its data. Without a handshake this sum never grows, so a raised
  // rd_req_valid_o holds until accepted.
  assign credit_ok_s    = ({1'b0, fifo_count_s} + {1'b0, outst_q}) < DEPTH_C;
  assign rd_req_valid_o = (state_q == DMA_XFER) && (rd_cnt_q < len_q) && credit_ok_s;
  assign rd_req_addr_o  = src_q + ADDR_WIDTH'(word_offset(rd_cnt_q));
  assign rd_fire_s      = rd_req_valid_o && rd_req_ready_i;

  // Responses outside XFER can only be leftovers of an aborted job.
  assign push_s         = rd_resp_valid_i && (state_q == DMA_XFER);

  assign wr_req_valid_o = (state_q == DMA_XFER) && !fifo_empty_s;
  assign wr_req_addr_o  = dst_q + ADDR_WIDTH'(word_offset(wr_cnt_q));
  assign wr_req_data_o  = fifo_head_s;
  assign wr_fire_s      = wr_req_valid_o && wr_req_ready_i;

  assign dma_done_o = done_q;
  assign dma_busy_o = busy_q;

  dma_fifo #(
    .WIDTH (DATA_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_s),
    .pop_i   (wr_fire_s),
    .din_i   (rd_resp_data_i),
    .dout_o  (fifo_head_s),
    .count_o (fifo_count_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // Next-state logic for the FSM, counters, latched command and status outputs.
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    outst_d  = outst_q;

    case (state_q)
      DMA_IDLE: begin
        if (dma_start_i) begin
          src_d    = {src_addr_i[ADDR_WIDTH-1:2], 2'b00};
          dst_d    = {dst_addr_i[ADDR_WIDTH-1:2], 2'b00};
          len_d    = length_i;
          rd_cnt_d = '0;
          wr_cnt_d = '0;
          outst_d  = '0;
          state_d  = (length_i == '0) ? DMA_DONE : DMA_XFER;
        end else begin
          state_d = DMA_IDLE;
        end
      end
      DMA_XFER: begin
        if (rd_fire_s) begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end else begin
          rd_cnt_d = rd_cnt_q;
        end
        if (wr_fire_s) begin
          wr_cnt_d = wr_cnt_q + 1'b1;
        end else begin
          wr_cnt_d = wr_cnt_q;
        end
        // Issue and response in the same cycle cancel out.
        case ({rd_fire_s, push_s})
          2'b10:   outst_d = outst_q + 1'b1;
          2'b01:   outst_d = (outst_q != '0) ? (outst_q - 1'b1) : outst_q;
          default: outst_d = outst_q;
        endcase
        // The last write being accepted implies all reads returned and the FIFO drained.
        if (wr_cnt_d == len_q) begin
          state_d = DMA_DONE;
        end else begin
          state_d = DMA_XFER;
        end
      end
      DMA_DONE: begin
        state_d = DMA_IDLE;
      end
      default: begin
        state_d = DMA_IDLE;
      end
    endcase

    // Busy covers the DONE cycle and the registered done pulse that follows it.
    busy_d = (state_d != DMA_IDLE) || (state_q == DMA_DONE);
    done_d = (state_q == DMA_DONE);
  end

  // State, command and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= DMA_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      outst_q  <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      outst_q  <= outst_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

endmodule
